conv_line_buffer: RTL and testbench

- Upstream feeder for the sliding-window stage.
- Accepts a raster-order pixel stream (DEPTH channels per beat) and stores the previous KERNEL_HEIGHT-1 image lines in circular line memories.
- Each accepted beat emits one vertical column of KERNEL_HEIGHT pixels per channel, broadcast to NUM_FILTER lanes, packed exactly as the sliding window's data_in.
- Also produces window-valid and frame timing so the downstream MAC samples only complete windows.

---
 rtl/conv_line_buffer_pkg.sv | 18 +
 rtl/conv_line_buffer_if.sv | 31 +++
 rtl/conv_line_buffer_line_mem.sv | 31 +++
 rtl/conv_line_buffer.sv | 126 ++++++++++++
 tb/tb_conv_line_buffer.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/conv_line_buffer_pkg.sv
// Shared constants and helpers for the line buffer and the sliding-window stage
// that consumes its column output.
package conv_line_buffer_pkg;

  // One stage for the line buffer output register, one for the sliding-window register.
  localparam int WV_PIPE_DEPTH = 2;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Element (n,k,j) position within a packed column vector, in units of samples.
  function automatic int col_index(input int n, input int k, input int j,
                                   input int kernel_height, input int depth);
    return n * (kernel_height * depth) + k * kernel_height + j;
  endfunction

endpackage

// File: rtl/conv_line_buffer_if.sv
// Pixel-in / column-out bundle of the line buffer.
// The proto_err signal exists only when LINEBUF_ERR_EN is defined.
interface conv_line_buffer_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int NUM_FILTER    = 3
);
  localparam int PIX_W = DATA_WIDTH * DEPTH;
  localparam int COL_W = DATA_WIDTH * KERNEL_HEIGHT * DEPTH * NUM_FILTER;

  logic             in_valid;
  logic [PIX_W-1:0] in_data;
  logic [COL_W-1:0] col_out;
  logic             col_valid;
  logic             window_valid;
  logic             frame_done;
`ifdef LINEBUF_ERR_EN
  logic             proto_err;

  modport master (output in_valid, in_data,
                  input  col_out, col_valid, window_valid, frame_done, proto_err);
  modport slave  (input  in_valid, in_data,
                  output col_out, col_valid, window_valid, frame_done, proto_err);
`else
  modport master (output in_valid, in_data,
                  input  col_out, col_valid, window_valid, frame_done);
  modport slave  (input  in_valid, in_data,
                  output col_out, col_valid, window_valid, frame_done);
`endif
endinterface

// File: rtl/conv_line_buffer_line_mem.sv
// One image line of pixels: read-before-write RAM with a registered read port.
// Contents are never reset; only the read register is.
module conv_line_buffer_line_mem
  import conv_line_buffer_pkg::*;
#(
  parameter int WORDS = 32,
  parameter int WIDTH = 48,
  localparam int AW   = cnt_width(WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [WORDS];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata_reg <= '0;
    else if (en) rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/conv_line_buffer.sv
// Line buffer feeding the sliding window: stores KERNEL_HEIGHT-1 lines and emits
// one vertical column per accepted beat. Optional check enabled by LINEBUF_ERR_EN.
module conv_line_buffer
  import conv_line_buffer_pkg::*;
#(
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int DEPTH         = 3,
  parameter int NUM_FILTER    = 3,
  parameter int DATA_WIDTH    = 16,
  parameter int IMG_WIDTH     = 32,
  parameter int IMG_HEIGHT    = 32
) (
  input logic             clk,
  input logic             reset,
  conv_line_buffer_if.slave bus
);
  localparam int LINES = KERNEL_HEIGHT - 1;
  localparam int PIX_W = DATA_WIDTH * DEPTH;
  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);
  localparam int PTR_W = cnt_width(LINES);

  logic [COL_W-1:0]         col_cnt_reg;
  logic [ROW_W-1:0]         row_cnt_reg;
  logic [PTR_W-1:0]         ptr_reg;
  logic [PTR_W-1:0]         ptr_out_reg;
  logic [PIX_W-1:0]         cur_pix_reg;
  logic                     col_valid_reg;
  logic                     frame_done_reg;
  logic [WV_PIPE_DEPTH-1:0] wv_pipe_reg;

  logic accept, col_last, row_last, tag;
  logic [PIX_W-1:0] line_rd  [LINES];
  logic [PIX_W-1:0] pix_col  [KERNEL_HEIGHT];

  assign accept   = bus.in_valid;
  assign col_last = (col_cnt_reg == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_cnt_reg == ROW_W'(IMG_HEIGHT - 1));
  assign tag      = (row_cnt_reg >= ROW_W'(LINES)) && (col_cnt_reg >= COL_W'(KERNEL_WIDTH - 1));

  genvar gi, gk, gj;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic [PTR_W:0] slot_sum;
      logic [PTR_W:0] slot;

      conv_line_buffer_line_mem #(.WORDS(IMG_WIDTH), .WIDTH(PIX_W)) u_mem (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .we    (accept && (ptr_reg == PTR_W'(gi))),
        .addr  (col_cnt_reg),
        .wdata (bus.in_data),
        .rdata (line_rd[gi])
      );

      // Slot (ptr+j) mod LINES holds line row-LINES+j, so j=0 is the oldest line.
      assign slot_sum = {1'b0, ptr_out_reg} + (PTR_W+1)'(gi);
      assign slot     = (slot_sum >= (PTR_W+1)'(LINES)) ? slot_sum - (PTR_W+1)'(LINES) : slot_sum;
      assign pix_col[gi] = line_rd[slot[PTR_W-1:0]];
    end

    assign pix_col[LINES] = cur_pix_reg;

    for (gi = 0; gi < NUM_FILTER; gi++) begin : g_lane
      for (gk = 0; gk < DEPTH; gk++) begin : g_chan
        for (gj = 0; gj < KERNEL_HEIGHT; gj++) begin : g_row
          assign bus.col_out[col_index(gi, gk, gj, KERNEL_HEIGHT, DEPTH) * DATA_WIDTH +: DATA_WIDTH]
            = pix_col[gj][gk*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt_reg    <= '0;
      row_cnt_reg    <= '0;
      ptr_reg        <= '0;
      ptr_out_reg    <= '0;
      cur_pix_reg    <= '0;
      col_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      wv_pipe_reg    <= '0;
    end else begin
      col_valid_reg  <= accept;
      frame_done_reg <= accept && col_last && row_last;
      wv_pipe_reg    <= {wv_pipe_reg[WV_PIPE_DEPTH-2:0], accept && tag};
      if (accept) begin
        cur_pix_reg <= bus.in_data;
        ptr_out_reg <= ptr_reg;
        if (col_last) begin
          col_cnt_reg <= '0;
          if (row_last) begin
            row_cnt_reg <= '0;
            ptr_reg     <= '0;
          end else begin
            row_cnt_reg <= row_cnt_reg + 1'b1;
            ptr_reg     <= (ptr_reg == PTR_W'(LINES - 1)) ? '0 : ptr_reg + 1'b1;
          end
        end else begin
          col_cnt_reg <= col_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.col_valid  = col_valid_reg;
  assign bus.frame_done = frame_done_reg;

`ifdef LINEBUF_ERR_EN
  logic proto_err_reg;

  // Sticky: a gap inside a line desynchronises the downstream window for good.
  always_ff @(posedge clk) begin
    if (reset)                                  proto_err_reg <= 1'b0;
    else if (!accept && (col_cnt_reg != '0))    proto_err_reg <= 1'b1;
  end

  assign bus.proto_err    = proto_err_reg;
  assign bus.window_valid = wv_pipe_reg[WV_PIPE_DEPTH-1] && !proto_err_reg;
`else
  assign bus.window_valid = wv_pipe_reg[WV_PIPE_DEPTH-1];
`endif
endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed bench for conv_line_buffer on a 4x4 image with a 3x3 kernel.
// Pixel value is row*16+col; LINEBUF_ERR_EN adds the protocol-error scenario.
module tb_conv_line_buffer;
  localparam int KW = 3, KH = 3, DEPTH = 1, NF = 1, DW = 16, IW = 4, IH = 4;
  localparam int CW = DW * KH * DEPTH * NF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_line_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .KERNEL_HEIGHT(KH), .NUM_FILTER(NF)) bus ();

  conv_line_buffer #(
    .KERNEL_WIDTH(KW), .KERNEL_HEIGHT(KH), .DEPTH(DEPTH), .NUM_FILTER(NF),
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   errors = 0;
  int   checks = 0;
  int   wv_seen, fd_seen;
  logic prev_tag;
  logic exp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(r * 16 + c);
  endfunction

  // One clock: drive a beat (or idle), then check what the edge produced.
  task automatic step(input logic v, input int r, input int c);
    logic [CW-1:0] col;
    bus.in_valid = v;
    bus.in_data  = v ? pix(r, c) : '0;
    @(posedge clk);
    #1;
    col = bus.col_out;
    check("col_valid", bus.col_valid, v);
    if (v) begin
      for (int j = 0; j < KH; j++) begin
        if (r - (KH - 1) + j >= 0)
          check($sformatf("col_j%0d_r%0dc%0d", j, r, c), col[j*DW +: DW], pix(r - (KH - 1) + j, c));
      end
      if (r == 2 && c == 1) check("col_r2c1", col, 48'h0021_0011_0001);
    end
    check("frame_done", bus.frame_done, v && r == IH - 1 && c == IW - 1);
    check("window_valid", bus.window_valid, prev_tag && !exp_err);
`ifdef LINEBUF_ERR_EN
    check("proto_err", bus.proto_err, exp_err);
`endif
    if (bus.window_valid) wv_seen++;
    if (bus.frame_done)   fd_seen++;
    prev_tag = v && (r >= KH - 1) && (c >= KW - 1);
    $display("beat v=%0b r=%0d c=%0d col_out=%h cv=%0b wv=%0b fd=%0b",
             v, r, c, col, bus.col_valid, bus.window_valid, bus.frame_done);
  endtask

  task automatic run_frame(input int gap_after_row1);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) step(1'b1, r, c);
      if (r == 1) for (int g = 0; g < gap_after_row1; g++) step(1'b0, r, 0);
    end
  endtask

  task automatic reset_cycle(input string tag);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(posedge clk);
    #1;
    check({tag, "_col_out"},      bus.col_out, '0);
    check({tag, "_col_valid"},    bus.col_valid, 1'b0);
    check({tag, "_window_valid"}, bus.window_valid, 1'b0);
    check({tag, "_frame_done"},   bus.frame_done, 1'b0);
`ifdef LINEBUF_ERR_EN
    check({tag, "_proto_err"},    bus.proto_err, 1'b0);
`endif
    reset    = 1'b0;
    prev_tag = 1'b0;
    exp_err  = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    prev_tag     = 1'b0;
    exp_err      = 1'b0;
    @(posedge clk);
    reset_cycle("reset");

    // Gap-free frame
    wv_seen = 0; fd_seen = 0;
    run_frame(0);
    step(1'b0, 0, 0);
    check("wv_count_first", wv_seen, 4);
    check("fd_count_first", fd_seen, 1);

    // Two frames back to back
    wv_seen = 0; fd_seen = 0;
    run_frame(0);
    run_frame(0);
    step(1'b0, 0, 0);
    check("wv_count_b2b", wv_seen, 8);
    check("fd_count_b2b", fd_seen, 2);

    // Five idle cycles between lines 1 and 2
    wv_seen = 0; fd_seen = 0;
    run_frame(5);
    step(1'b0, 0, 0);
    check("wv_count_gap", wv_seen, 4);
    check("fd_count_gap", fd_seen, 1);

    // Reset right after the (2,2) beat, with its window tag still in flight
    for (int r = 0; r < 2; r++) for (int c = 0; c < IW; c++) step(1'b1, r, c);
    for (int c = 0; c <= 2; c++) step(1'b1, 2, c);
    reset_cycle("midreset");
    wv_seen = 0; fd_seen = 0;
    run_frame(0);
    step(1'b0, 0, 0);
    check("wv_count_after_reset", wv_seen, 4);
    check("fd_count_after_reset", fd_seen, 1);

`ifdef LINEBUF_ERR_EN
    // Mid-line gap at row 1 col 2: sticky error, no windows for the rest of the frame
    wv_seen = 0; fd_seen = 0;
    for (int c = 0; c < IW; c++) step(1'b1, 0, c);
    step(1'b1, 1, 0);
    step(1'b1, 1, 1);
    exp_err = 1'b1;
    step(1'b0, 1, 2);
    for (int c = 2; c < IW; c++) step(1'b1, 1, c);
    for (int r = 2; r < IH; r++) for (int c = 0; c < IW; c++) step(1'b1, r, c);
    step(1'b0, 0, 0);
    check("wv_count_proto", wv_seen, 0);
    check("fd_count_proto", fd_seen, 1);
    reset_cycle("proto_reset");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
